// File: rtl/axis_lmac_tx_mux.sv
// +--------------------------------------------------------------------------+
// | axis_lmac_tx_mux : packet-granular N:1 AXIS mux into the FMAC TX FIFOs.  |
// | Optional macro AXIS_TXMUX_STRICT_PRI_EN selects strict priority.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module axis_lmac_tx_mux #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 64,
  parameter int USEDW_W   = 13,
  parameter int START_THR = 7990,
  parameter int MAX_BYTES = 1518
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          s_axis_tvalid,
  output logic [NUM_CH-1:0]          s_axis_tready,
  input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_CH*DATA_W/8-1:0] s_axis_tkeep,
  input  logic [NUM_CH-1:0]          s_axis_tlast,
  output logic                       mac_data_wr,
  output logic [DATA_W-1:0]          mac_data,
  input  logic                       mac_full,
  input  logic [USEDW_W-1:0]         mac_usedw,
  output logic                       mac_cnt_wr,
  output logic [31:0]                mac_cnt,
  output logic                       busy
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    CNT  = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  grant;
  logic [15:0] count;
`ifndef AXIS_TXMUX_STRICT_PRI_EN
  logic [2:0]  last;
`endif

  logic              found;
  logic [2:0]        pick;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic [3:0]        ones;
  logic [16:0]       sum;
  logic [15:0]       count_next;
  logic              oversize;
  logic              handshake;

  // Arbitration: first requester in search order; loops unroll to constant indices
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef AXIS_TXMUX_STRICT_PRI_EN
        if (!found && (i == k) && s_axis_tvalid[i]) begin
`else
        if (!found && (i == ((int'(last) + 1 + k) % NUM_CH)) && s_axis_tvalid[i]) begin
`endif
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    sel_keep      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == 3'(i)) begin
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        sel_data         = s_axis_tdata[i*DATA_W +: DATA_W];
        sel_keep         = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        s_axis_tready[i] = (state == XFER) && !mac_full;
      end
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      ones = ones + {3'b000, sel_keep[i]};
    end
  end

  assign sum        = {1'b0, count} + {13'b0, ones};
  assign count_next = sum[16] ? 16'hFFFF : sum[15:0];
  assign oversize   = (count_next > 16'(MAX_BYTES));
  assign handshake  = (state == XFER) && sel_valid && !mac_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      count       <= '0;
`ifndef AXIS_TXMUX_STRICT_PRI_EN
      last        <= 3'(NUM_CH - 1);
`endif
      mac_data_wr <= 1'b0;
      mac_data    <= '0;
      mac_cnt_wr  <= 1'b0;
      mac_cnt     <= '0;
      busy        <= 1'b0;
    end else begin
      mac_data_wr <= 1'b0;
      mac_cnt_wr  <= 1'b0;
      case (state)
        IDLE: begin
          if (found && (mac_usedw <= USEDW_W'(START_THR))) begin
            grant <= pick;
            busy  <= 1'b1;
            state <= ARB;
          end
        end
        ARB: begin
          count <= '0;
`ifndef AXIS_TXMUX_STRICT_PRI_EN
          last  <= grant;
`endif
          state <= XFER;
        end
        XFER: begin
          if (handshake) begin
            mac_data    <= sel_data;
            mac_data_wr <= 1'b1;
            count       <= count_next;
            // Count word is registered on the tlast beat so it lands in the CNT cycle
            if (sel_last) begin
              mac_cnt_wr <= 1'b1;
              mac_cnt    <= {oversize, 12'b0, grant, count_next};
              state      <= CNT;
            end
          end
        end
        CNT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_lmac_tx_mux.sv
// Directed self-checking bench for axis_lmac_tx_mux (default parameters).
`default_nettype none

module tb_axis_lmac_tx_mux;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 64;
  localparam int USEDW_W   = 13;
  localparam int START_THR = 7990;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        s_axis_tvalid;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata;
  logic [NUM_CH*8-1:0]      s_axis_tkeep;
  logic [NUM_CH-1:0]        s_axis_tlast;
  logic                     mac_data_wr;
  logic [DATA_W-1:0]        mac_data;
  logic                     mac_full;
  logic [USEDW_W-1:0]       mac_usedw;
  logic                     mac_cnt_wr;
  logic [31:0]              mac_cnt;
  logic                     busy;

  int n_cmp = 0;
  int n_bad = 0;
  int onehot_bad = 0;
  logic [63:0] data_q[$];
  logic [31:0] cnt_q[$];

  axis_lmac_tx_mux #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .USEDW_W(USEDW_W),
    .START_THR(START_THR), .MAX_BYTES(1518)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast),
    .mac_data_wr(mac_data_wr), .mac_data(mac_data),
    .mac_full(mac_full), .mac_usedw(mac_usedw),
    .mac_cnt_wr(mac_cnt_wr), .mac_cnt(mac_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (mac_data_wr) data_q.push_back(mac_data);
      if (mac_cnt_wr) cnt_q.push_back(mac_cnt);
      if ($countones(s_axis_tready) > 1) onehot_bad++;
    end
  end

  function automatic logic [63:0] mk(input int ch, input int b);
    return {16'hC0DE, 8'(ch), 8'h00, 32'(b)};
  endfunction

  task automatic drive(input int ch, input int b, input logic [7:0] keep, input logic last);
    s_axis_tvalid[ch]            = 1'b1;
    s_axis_tdata[ch*DATA_W +: 64] = mk(ch, b);
    s_axis_tkeep[ch*8 +: 8]       = keep;
    s_axis_tlast[ch]             = last;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = '0;
    mac_full = 1'b0; mac_usedw = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    data_q.delete(); cnt_q.delete();
  endtask

  task automatic send_pkt(input int ch, input int nbeats, input logic [7:0] mid_keep,
                          input logic [7:0] last_keep);
    int beat = 0;
    int guard = 0;
    drive(ch, 0, (nbeats == 1) ? last_keep : mid_keep, nbeats == 1);
    while (beat < nbeats && guard < 2000) begin
      @(negedge clk); guard++;
      if (s_axis_tready[ch]) begin
        @(posedge clk); #1;
        beat++;
        if (beat < nbeats) drive(ch, beat, (beat == nbeats-1) ? last_keep : mid_keep, beat == nbeats-1);
        else s_axis_tvalid[ch] = 1'b0;
      end
    end
    n_cmp++;
    if (beat !== nbeats) begin n_bad++; $display("FAIL send_ch%0d: beats accepted %0d, required %0d", ch, beat, nbeats); end
  endtask

  task automatic wait_cnt(input int n);
    int g = 0;
    while (cnt_q.size() < n && g < 100) begin @(negedge clk); g++; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (s_axis_tready !== 4'b0) begin n_bad++; $display("FAIL rst_tready: got %b need 0", s_axis_tready); end
    n_cmp++; if (mac_data_wr !== 1'b0) begin n_bad++; $display("FAIL rst_data_wr: got %b need 0", mac_data_wr); end
    n_cmp++; if (mac_cnt_wr !== 1'b0) begin n_bad++; $display("FAIL rst_cnt_wr: got %b need 0", mac_cnt_wr); end
    n_cmp++; if (mac_cnt !== 32'h0) begin n_bad++; $display("FAIL rst_cnt: got %h need 0", mac_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b need 0", busy); end
  endtask

  task automatic test_single();
    int bad = 0;
    do_reset();
    send_pkt(0, 3, 8'hFF, 8'h0F);
    wait_cnt(1);
    n_cmp++; if (data_q.size() !== 3) begin n_bad++; $display("FAIL single_nwr: got %0d need 3", data_q.size()); end
    for (int i = 0; i < 3; i++) if (data_q.size() > i && data_q[i] !== mk(0, i)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL single_data: %0d wrong words, need 0", bad); end
    n_cmp++; if (cnt_q.size() !== 1 || cnt_q[0] !== 32'h0000_0014) begin n_bad++; $display("FAIL single_cnt: got %h (n=%0d) need 00000014", (cnt_q.size() > 0) ? cnt_q[0] : 32'hx, cnt_q.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: busy %b need 0", busy); end
  endtask

  task automatic test_keep_edge();
    do_reset();
    send_pkt(0, 2, 8'hA5, 8'h00);
    wait_cnt(1);
    n_cmp++; if (data_q.size() !== 2) begin n_bad++; $display("FAIL keep_nwr: got %0d need 2", data_q.size()); end
    n_cmp++; if (cnt_q.size() !== 1 || cnt_q[0] !== 32'h0000_0004) begin n_bad++; $display("FAIL keep_cnt: got %h need 00000004", (cnt_q.size() > 0) ? cnt_q[0] : 32'hx); end
  endtask

  task automatic test_round_robin();
    int hs = 0;
    int g = 0;
    int n1 = 0;
    int n3 = 0;
    int bad = 0;
    logic [2:0] exp_ch [4];
`ifdef AXIS_TXMUX_STRICT_PRI_EN
    exp_ch = '{3'd1, 3'd1, 3'd1, 3'd1};
`else
    exp_ch = '{3'd1, 3'd3, 3'd1, 3'd3};
`endif
    do_reset();
    drive(1, 0, 8'hFF, 1'b1);
    drive(3, 0, 8'hFF, 1'b1);
    while (hs < 4 && g < 200) begin
      @(negedge clk); g++;
      if (s_axis_tready[1] || s_axis_tready[3]) begin
        logic r1;
        r1 = s_axis_tready[1];
        @(posedge clk); #1;
        hs++;
        if (r1) begin n1++; drive(1, n1, 8'hFF, 1'b1); end
        else begin n3++; drive(3, n3, 8'hFF, 1'b1); end
        if (hs == 4) s_axis_tvalid = '0;
      end
    end
    wait_cnt(4);
    n_cmp++; if (cnt_q.size() !== 4) begin n_bad++; $display("FAIL rr_ncnt: got %0d need 4", cnt_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cnt_q.size() <= i || cnt_q[i][18:16] !== exp_ch[i] || cnt_q[i][15:0] !== 16'd8) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %h need ch %0d count 8", i, (cnt_q.size() > i) ? cnt_q[i] : 32'hx, exp_ch[i]);
      end
    end
    for (int i = 0; i < 4; i++) if (data_q.size() > i && data_q[i][47:40] !== 8'(exp_ch[i])) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL rr_data: %0d words from wrong channel, need 0", bad); end
  endtask

  task automatic test_backpressure();
    int g = 0;
    int beats = 0;
    int low = 0;
    int fullc = 0;
    int bad = 0;
    logic ready;
    do_reset();
    drive(0, 0, 8'hFF, 1'b0);
    do begin @(negedge clk); g++; end while (!s_axis_tready[0] && g < 20);
    while (beats < 10 && g < 200) begin
      ready = s_axis_tready[0];
      if (ready === mac_full) bad++;
      if (!ready) low++;
      @(posedge clk); #1;
      if (ready) begin
        beats++;
        if (beats < 10) drive(0, beats, 8'hFF, beats == 9);
        else s_axis_tvalid[0] = 1'b0;
      end
      if (beats >= 4 && fullc < 5) begin mac_full = 1'b1; fullc++; end
      else mac_full = 1'b0;
      @(negedge clk); g++;
    end
    wait_cnt(1);
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_ready_follows_full: %0d bad cycles, need 0", bad); end
    n_cmp++; if (low !== 5) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d need 5", low); end
    n_cmp++; if (data_q.size() !== 10) begin n_bad++; $display("FAIL bp_nwr: got %0d need 10", data_q.size()); end
    bad = 0;
    for (int i = 0; i < 10; i++) if (data_q.size() > i && data_q[i] !== mk(0, i)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_data: %0d wrong words, need 0", bad); end
    n_cmp++; if (cnt_q.size() !== 1 || cnt_q[0] !== 32'h0000_0050) begin n_bad++; $display("FAIL bp_cnt: got %h need 00000050", (cnt_q.size() > 0) ? cnt_q[0] : 32'hx); end
  endtask

  task automatic test_threshold();
    int bad = 0;
    do_reset();
    mac_usedw = USEDW_W'(START_THR + 1);
    drive(2, 0, 8'hFF, 1'b1);
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0 || s_axis_tready !== 4'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL thr_hold: %0d cycles left IDLE, need 0", bad); end
    @(posedge clk); #1 mac_usedw = USEDW_W'(START_THR);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL thr_same_cycle: busy %b need 0", busy); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || s_axis_tready !== 4'b0) begin n_bad++; $display("FAIL thr_arb: busy %b tready %b need 1 0000", busy, s_axis_tready); end
    @(negedge clk);
    n_cmp++; if (s_axis_tready !== 4'b0100) begin n_bad++; $display("FAIL thr_xfer: tready %b need 0100", s_axis_tready); end
    @(posedge clk); #1 s_axis_tvalid = '0;
    wait_cnt(1);
    n_cmp++; if (cnt_q.size() !== 1 || cnt_q[0] !== 32'h0002_0008) begin n_bad++; $display("FAIL thr_cnt: got %h need 00020008", (cnt_q.size() > 0) ? cnt_q[0] : 32'hx); end
    mac_usedw = '0;
  endtask

  task automatic test_oversize();
    do_reset();
    send_pkt(0, 191, 8'hFF, 8'hFF);
    wait_cnt(1);
    n_cmp++; if (data_q.size() !== 191) begin n_bad++; $display("FAIL ovs_nwr: got %0d need 191", data_q.size()); end
    n_cmp++; if (cnt_q.size() !== 1 || cnt_q[0] !== 32'h8000_05F8) begin n_bad++; $display("FAIL ovs_cnt: got %h need 800005F8", (cnt_q.size() > 0) ? cnt_q[0] : 32'hx); end
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    int g = 0;
    data_q.delete(); cnt_q.delete();
    drive(0, 0, 8'hFF, 1'b0);
    while (hs < 2 && g < 50) begin
      @(negedge clk); g++;
      if (s_axis_tready[0]) begin
        @(posedge clk); #1;
        hs++;
        drive(0, hs, 8'hFF, 1'b0);
      end
    end
    rst = 1'b1;
    s_axis_tvalid = '0;
    #1;
    n_cmp++; if (s_axis_tready !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctl: tready %b busy %b need 0 0", s_axis_tready, busy); end
    n_cmp++; if (mac_data_wr !== 1'b0 || mac_data !== 64'h0) begin n_bad++; $display("FAIL mid_rst_data: wr %b data %h need 0", mac_data_wr, mac_data); end
    n_cmp++; if (mac_cnt_wr !== 1'b0 || mac_cnt !== 32'h0) begin n_bad++; $display("FAIL mid_rst_cnt: wr %b cnt %h need 0", mac_cnt_wr, mac_cnt); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (cnt_q.size() !== 0) begin n_bad++; $display("FAIL mid_no_cnt: got %0d count words need 0", cnt_q.size()); end
    data_q.delete();
    send_pkt(0, 2, 8'hFF, 8'h0F);
    wait_cnt(1);
    n_cmp++; if (cnt_q.size() !== 1 || cnt_q[0] !== 32'h0000_000C) begin n_bad++; $display("FAIL mid_after_cnt: got %h need 0000000C", (cnt_q.size() > 0) ? cnt_q[0] : 32'hx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_keep_edge();
    test_round_robin();
    test_backpressure();
    test_threshold();
    test_oversize();
    test_reset_mid();
    n_cmp++;
    if (onehot_bad !== 0) begin n_bad++; $display("FAIL tready_onehot: %0d cycles with >1 ready, need 0", onehot_bad); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
